serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 117 +++++++++++
 tb/tb_serial_deserializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel converter with a one-word output slot and a FULL
// holding state, so a completed word waits in the shift register while the slot is occupied.
module serial_deserializer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          s_valid,
  input  logic                          s_data,
  input  logic                          s_start,
  input  logic                          p_ready,
  input  logic                          clear_err,
  output logic [WORD_WIDTH-1:0]         p_data,
  output logic                          p_valid,
  output logic [$clog2(WORD_WIDTH):0]   bit_count,
  output logic                          busy,
  output logic                          overrun,
  output logic                          framing_err
);

  localparam int CW = $clog2(WORD_WIDTH) + 1;
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t                state_reg;
  logic [WORD_WIDTH-1:0] sr_reg;
  logic [WORD_WIDTH-1:0] sr_shifted;
  logic [WORD_WIDTH-1:0] p_data_reg;
  logic                  p_valid_reg;
  logic [CW-1:0]         bit_count_reg;
  logic                  overrun_reg;
  logic                  framing_err_reg;
  logic                  accept;
  logic                  slot_free;

  assign accept     = enable & s_valid;
  // The slot counts as free when the current word is leaving on this same edge.
  assign slot_free  = !p_valid_reg | p_ready;
  assign sr_shifted = {s_data, sr_reg[WORD_WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      sr_reg          <= '0;
      p_data_reg      <= '0;
      p_valid_reg     <= 1'b0;
      bit_count_reg   <= '0;
      overrun_reg     <= 1'b0;
      framing_err_reg <= 1'b0;
    end else begin
      // Clear first so that a set later in this block wins on the same edge.
      if (clear_err) begin
        overrun_reg     <= 1'b0;
        framing_err_reg <= 1'b0;
      end
      if (p_valid_reg && p_ready)
        p_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept && s_start) begin
            sr_reg        <= sr_shifted;
            bit_count_reg <= COUNT_ONE;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            if (s_start) begin
              sr_reg          <= sr_shifted;
              bit_count_reg   <= COUNT_ONE;
              framing_err_reg <= 1'b1;
            end else if (bit_count_reg == COUNT_LAST) begin
              if (slot_free) begin
                p_data_reg    <= sr_shifted;
                p_valid_reg   <= 1'b1;
                bit_count_reg <= '0;
                state_reg     <= IDLE;
              end else begin
                sr_reg        <= sr_shifted;
                bit_count_reg <= COUNT_FULL;
                state_reg     <= FULL;
              end
            end else begin
              sr_reg        <= sr_shifted;
              bit_count_reg <= bit_count_reg + COUNT_ONE;
            end
          end
        end
        FULL: begin
          if (accept)
            overrun_reg <= 1'b1;
          // Transfer does not depend on enable; the held word moves out as soon as the slot frees.
          if (slot_free) begin
            p_data_reg    <= sr_reg;
            p_valid_reg   <= 1'b1;
            bit_count_reg <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign p_data      = p_data_reg;
  assign p_valid     = p_valid_reg;
  assign bit_count   = bit_count_reg;
  assign busy        = (state_reg != IDLE);
  assign overrun     = overrun_reg;
  assign framing_err = framing_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer at WORD_WIDTH=8: expected words are queued
// when a frame's last bit is driven and popped when the output handshake completes.
module tb_serial_deserializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_data = 1'b0;
  logic         s_start = 1'b0;
  logic         p_ready = 1'b0;
  logic         clear_err = 1'b0;
  logic [W-1:0] p_data;
  logic         p_valid;
  logic [3:0]   bit_count;
  logic         busy;
  logic         overrun;
  logic         framing_err;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic         stalled_prev = 1'b0;
  logic [W-1:0] held_data = '0;

  serial_deserializer #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_start(s_start), .p_ready(p_ready), .clear_err(clear_err), .p_data(p_data),
    .p_valid(p_valid), .bit_count(bit_count), .busy(busy), .overrun(overrun),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    s_valid = 1'b1;
    s_data  = b;
    s_start = st;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  // Bits lo..hi of word, LSB first; bit 0 carries s_start; completing bit 7 queues the word.
  task automatic send_range(input logic [W-1:0] word, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      send_bit(word[i], i == 0);
    if (hi == W - 1)
      exp_q.push_back(word);
  endtask

  // Scoreboard and hold monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (stalled_prev && p_valid)
        check("hold_stable", p_data, held_data);
      if (p_valid && p_ready) begin
        if (exp_q.size() == 0)
          check("sb_unexpected_word", p_data, 64'hDEAD);
        else
          check("sb_word", p_data, exp_q.pop_front());
      end
      stalled_prev <= p_valid && !p_ready;
      held_data    <= p_data;
    end else begin
      stalled_prev <= 1'b0;
    end
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_p_valid", p_valid, 0);
    check("rst_p_data", p_data, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_busy", busy, 0);

    // Single frame 0xA5 with an always-ready sink.
    p_ready = 1'b1;
    send_range(8'hA5, 0, 2);
    check("a5_mid_count", bit_count, 3);
    check("a5_mid_busy", busy, 1);
    send_range(8'hA5, 3, 7);
    check("a5_p_valid", p_valid, 1);
    check("a5_p_data", p_data, 8'hA5);
    check("a5_count_zero", bit_count, 0);
    tick();
    check("a5_p_valid_one_cycle", p_valid, 0);

    // Stalled sink: second word parks in FULL, extra bit overruns, then drains back-to-back.
    p_ready = 1'b0;
    send_range(8'h3C, 0, 7);
    send_range(8'hC3, 0, 7);
    check("full_p_data", p_data, 8'h3C);
    check("full_count", bit_count, 8);
    check("full_busy", busy, 1);
    check("full_no_overrun_yet", overrun, 0);
    send_bit(1'b1, 1'b0);
    check("full_overrun", overrun, 1);
    check("full_count_held", bit_count, 8);
    p_ready = 1'b1;
    tick();
    check("drain_second_word", p_data, 8'hC3);
    check("drain_p_valid", p_valid, 1);
    check("drain_idle", busy, 0);
    tick();
    check("drain_done", p_valid, 0);

    // Sticky clear, then set/clear collision on a fresh overrun.
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_overrun", overrun, 0);
    p_ready = 1'b0;
    send_range(8'h11, 0, 7);
    send_range(8'h22, 0, 7);
    clear_err = 1'b1;
    send_bit(1'b0, 1'b1);
    check("set_beats_clear", overrun, 1);
    tick();
    clear_err = 1'b0;
    check("clear_next_cycle", overrun, 0);
    p_ready = 1'b1;
    tick();
    tick();

    // Restart mid-frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("frm_before", framing_err, 0);
    send_range(8'h5A, 0, 0);
    check("frm_set", framing_err, 1);
    check("frm_count_restart", bit_count, 1);
    send_range(8'h5A, 1, 7);
    check("frm_p_data", p_data, 8'h5A);
    tick();

    // Enable low freezes the serial side while s_valid/s_start toggle.
    send_range(8'h81, 0, 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = i[0];
      s_start = 1'b1;
      s_data  = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_start = 1'b0;
    check("en_count_frozen", bit_count, 4);
    check("en_busy", busy, 1);
    enable = 1'b1;
    send_range(8'h81, 4, 7);
    check("en_p_data", p_data, 8'h81);
    tick();

    // Asynchronous reset mid-frame; framing_err is still set from the restart above.
    send_range(8'hFF, 0, 3);
    reset = 1'b1;
    #1;
    check("arst_p_data", p_data, 0);
    check("arst_p_valid", p_valid, 0);
    check("arst_count", bit_count, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    check("arst_framing", framing_err, 0);
    #2;
    reset = 1'b0;
    tick();
    send_range(8'hFF, 0, 7);
    check("post_rst_p_data", p_data, 8'hFF);
    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
